// File: rtl/scarv_soc_periph_pkg.sv
// Shared types and constants for the peripheral bridge slice.
// The peripheral window is a single aligned 2**PERIPH_WINDOW_BITS byte region.
package scarv_soc_periph_pkg;

  localparam int PERIPH_WINDOW_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    WAIT,
    RESP,
    DRAIN
  } bridge_state_t;

  // True when the upper address bits select the peripheral window.
  function automatic logic in_window(
    input logic [31-PERIPH_WINDOW_BITS:0] addr_hi,
    input logic [31-PERIPH_WINDOW_BITS:0] base_hi
  );
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/scarv_soc_timeout_ctr.sv
// Saturating cycle counter used to bound how long a transaction may stall.
// expired is raised during the LIMIT-th enabled cycle after a clear and stays
// raised until the next clear, so the owner can act on it at that clock edge.
module scarv_soc_timeout_ctr #(
  parameter int LIMIT = 1024,
  parameter int TW    = 11
) (
  input  logic g_clk,
  input  logic g_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);
  localparam logic [TW-1:0] SAT  = TW'(LIMIT);

  logic [TW-1:0] count;

  // Count enabled cycles since the last clear, holding at LIMIT instead of wrapping.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= LAST);

endmodule

// File: rtl/scarv_soc_periph_bridge.sv
// Single-outstanding request bridge in front of the peripheral subsystem.
// Requests outside the 64KB window at PERIPH_BASE complete upstream with an error.
// Optional feature macro: SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN adds a stall timeout
// that errors out stuck transactions and drains a late downstream response.
module scarv_soc_periph_bridge
  import scarv_soc_periph_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE    = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          TW             = 11
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        s_req,
  output logic        s_gnt,
  input  logic        s_wen,
  input  logic [3:0]  s_strb,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_recv,
  input  logic        s_ack,
  output logic [31:0] s_rdata,
  output logic        s_error,
  output logic        m_req,
  input  logic        m_gnt,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_recv,
  output logic        m_ack,
  input  logic [31:0] m_rdata,
  input  logic        m_error
);

  if ((TIMEOUT_CYCLES < 2) || ((2 ** TW) <= TIMEOUT_CYCLES)) begin : g_bad_timeout_cfg
    $error("scarv_soc_periph_bridge: TIMEOUT_CYCLES must be >= 2 and below 2**TW");
  end

  bridge_state_t state;
  logic          win_hit;

  assign win_hit = in_window(s_addr[31:PERIPH_WINDOW_BITS],
                             PERIPH_BASE[31:PERIPH_WINDOW_BITS]);

`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
  logic ctr_clear;
  logic ctr_en;
  logic ctr_expired;
  logic drain_pend;

  assign ctr_clear = ((state == IDLE) && s_req) ||
                     ((state == RESP) && s_ack && drain_pend);
  assign ctr_en    = (state == FWD) || (state == WAIT) || (state == DRAIN);

  scarv_soc_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .TW    (TW)
  ) u_timeout_ctr (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );
`endif

  // Bridge FSM; every handshake output is a register so it stays stable until its handshake.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state   <= IDLE;
      s_gnt   <= 1'b1;
      s_recv  <= 1'b0;
      s_rdata <= '0;
      s_error <= 1'b0;
      m_req   <= 1'b0;
      m_ack   <= 1'b0;
      m_wen   <= 1'b0;
      m_strb  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
      drain_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_req) begin
            s_gnt   <= 1'b0;
            m_wen   <= s_wen;
            m_strb  <= s_strb;
            m_addr  <= s_addr;
            m_wdata <= s_wdata;
            if (win_hit) begin
              m_req <= 1'b1;
              state <= FWD;
            end else begin
              s_recv  <= 1'b1;
              s_error <= 1'b1;
              s_rdata <= '0;
              state   <= RESP;
            end
          end
        end
        FWD: begin
          if (m_gnt) begin
            m_req <= 1'b0;
            if (m_recv) begin
              s_recv  <= 1'b1;
              s_rdata <= m_wen ? '0 : m_rdata;
              s_error <= m_error;
              state   <= RESP;
            end else begin
              m_ack <= 1'b1;
              state <= WAIT;
            end
          end
`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
          else if (ctr_expired) begin
            m_req   <= 1'b0;
            s_recv  <= 1'b1;
            s_error <= 1'b1;
            s_rdata <= '0;
            state   <= RESP;
          end
`endif
        end
        WAIT: begin
          if (m_recv) begin
            m_ack   <= 1'b0;
            s_recv  <= 1'b1;
            s_rdata <= m_wen ? '0 : m_rdata;
            s_error <= m_error;
            state   <= RESP;
          end
`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
          else if (ctr_expired) begin
            m_ack      <= 1'b0;
            s_recv     <= 1'b1;
            s_error    <= 1'b1;
            s_rdata    <= '0;
            drain_pend <= 1'b1;
            state      <= RESP;
          end
`endif
        end
        RESP: begin
          if (s_ack) begin
            s_recv  <= 1'b0;
            s_error <= 1'b0;
            s_rdata <= '0;
`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
            if (drain_pend) begin
              drain_pend <= 1'b0;
              m_ack      <= 1'b1;
              state      <= DRAIN;
            end else begin
              s_gnt <= 1'b1;
              state <= IDLE;
            end
`else
            s_gnt <= 1'b1;
            state <= IDLE;
`endif
          end
        end
`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
        DRAIN: begin
          if (m_recv || ctr_expired) begin
            m_ack <= 1'b0;
            s_gnt <= 1'b1;
            state <= IDLE;
          end
        end
`endif
        default: begin
          m_req  <= 1'b0;
          m_ack  <= 1'b0;
          s_recv <= 1'b0;
          s_gnt  <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
